// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
//   op/funct   : instruction fields from the IR (valid from DECODE onward)
//   zero       : ALU zero flag
//   mem_ready  : memory completes the current read/write this cycle
//   pcen .. alucontrol : datapath enables and mux selects
//   state      : current controller state (debug/verification)
//   illegal_op : one-cycle pulse when an undefined opcode is decoded
// The controller takes the slave modport and the datapath takes the master modport.
interface multicycle_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;
    logic       illegal_op;

    modport slave (
        input  op, funct, zero, mem_ready,
        output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, state, illegal_op
    );

    modport master (
        output op, funct, zero, mem_ready,
        input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, state, illegal_op
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM. Sequences one instruction through FETCH, DECODE and
// 1-3 execute/memory/writeback states, stalling in FETCH, MEMRD and MEMWR until
// mem_ready. Outputs are decoded from the current state; pcen additionally uses the
// zero flag, and the FETCH enables follow mem_ready.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; forces FETCH and holds all write enables low
//   bus   : multicycle_controller_if.slave (op, funct, zero, mem_ready in; controls out)
module multicycle_controller (
    input  logic                        clk,
    input  logic                        rst_n,
    multicycle_controller_if.slave      bus
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,  S_DECODE  = 4'd1,  S_MEMADR  = 4'd2,  S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,  S_MEMWR   = 4'd5,  S_RTYPEEX = 4'd6,  S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,  S_ADDIEX  = 4'd9,  S_ADDIWB  = 4'd10, S_JEX     = 4'd11
    } state_e;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_e state_q, state_d;

    logic       pcwrite_s, branch_s, iord_s, memwrite_s, irwrite_s, regdst_s;
    logic       memtoreg_s, regwrite_s, alusrca_s, illegal_s;
    logic [1:0] alusrcb_s, pcsrc_s;
    logic [2:0] alucontrol_s;

    // R-type ALU operation; unknown funct codes fall back to add.
    function automatic logic [2:0] funct_to_alu(input logic [5:0] funct);
        logic [2:0] alu;
        case (funct)
            6'b100000: alu = ALU_ADD;
            6'b100010: alu = ALU_SUB;
            6'b100100: alu = ALU_AND;
            6'b100101: alu = ALU_OR;
            6'b101010: alu = ALU_SLT;
            default:   alu = ALU_ADD;
        endcase
        return alu;
    endfunction

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and state-decoded control outputs.
    always_comb begin
        state_d      = S_FETCH;
        pcwrite_s    = 1'b0;
        branch_s     = 1'b0;
        iord_s       = 1'b0;
        memwrite_s   = 1'b0;
        irwrite_s    = 1'b0;
        regdst_s     = 1'b0;
        memtoreg_s   = 1'b0;
        regwrite_s   = 1'b0;
        alusrca_s    = 1'b0;
        alusrcb_s    = 2'b00;
        pcsrc_s      = 2'b00;
        alucontrol_s = 3'b000;
        illegal_s    = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb_s    = 2'b01;
                alucontrol_s = ALU_ADD;
                // IR load and PC+4 happen only on the cycle the fetch completes.
                irwrite_s    = bus.mem_ready;
                pcwrite_s    = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut here.
                alusrcb_s    = 2'b11;
                alucontrol_s = ALU_ADD;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca_s    = 1'b1;
                alusrcb_s    = 2'b10;
                alucontrol_s = ALU_ADD;
                if (bus.op == OP_LW) begin
                    state_d = S_MEMRD;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_MEMRD: begin
                iord_s = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMWB: begin
                memtoreg_s = 1'b1;
                regwrite_s = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                // Write strobe stays up until the memory accepts it.
                iord_s     = 1'b1;
                memwrite_s = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_RTYPEEX: begin
                alusrca_s    = 1'b1;
                alucontrol_s = funct_to_alu(bus.funct);
                state_d      = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regdst_s   = 1'b1;
                regwrite_s = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQEX: begin
                alusrca_s    = 1'b1;
                alucontrol_s = ALU_SUB;
                pcsrc_s      = 2'b01;
                branch_s     = 1'b1;
                state_d      = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca_s    = 1'b1;
                alusrcb_s    = 2'b10;
                alucontrol_s = ALU_ADD;
                state_d      = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_s = 1'b1;
                state_d    = S_FETCH;
            end
            S_JEX: begin
                pcsrc_s   = 2'b10;
                pcwrite_s = 1'b1;
                state_d   = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Write enables are qualified by rst_n so they drop immediately on reset,
    // even though FETCH would otherwise follow mem_ready.
    assign bus.pcen       = rst_n & (pcwrite_s | (branch_s & bus.zero));
    assign bus.memwrite   = rst_n & memwrite_s;
    assign bus.irwrite    = rst_n & irwrite_s;
    assign bus.regwrite   = rst_n & regwrite_s;
    assign bus.illegal_op = rst_n & illegal_s;
    assign bus.iord       = iord_s;
    assign bus.regdst     = regdst_s;
    assign bus.memtoreg   = memtoreg_s;
    assign bus.alusrca    = alusrca_s;
    assign bus.alusrcb    = alusrcb_s;
    assign bus.pcsrc      = pcsrc_s;
    assign bus.alucontrol = alucontrol_s;
    assign bus.state      = state_q;
endmodule
